// File: rtl/exc_ctrl.sv
// exc_ctrl: MIPS32 exception controller at the MEM/WB boundary.
// Decides whether the MEM instruction traps. On a trap it drives the CP0 exception
// inputs for one cycle and holds flush_o high for FLUSH_CYCLES cycles. While the
// flush is active it also drives the redirect target new_pc_o.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] VEC_OFFSET   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic        adel_fetch_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        eret_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        tlbmiss_i,
    input  logic        load_i,
    input  logic [31:0] badvaddr_data_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_ebase_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_addr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] exc_type_o,
    output logic [31:0] exc_addr_o,
    output logic        in_delay_slot_o,
    output logic        tlbmiss_o,
    output logic        load_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    // CP0 register numbers seen on the WB mtc0 port.
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    // Exception codes handed to CP0.
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_0010;
    localparam logic [31:0] EXC_TLB     = 32'h0000_0000;

    // Counter reload value. The flush length is FLUSH_CYCLES, in the range 1..15.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;

    logic [31:0] w_eff_status;
    logic [31:0] w_eff_epc;
    logic [31:0] w_eff_ebase;
    logic [7:0]  w_eff_ip;
    logic        w_int_pending;

    logic        w_any;
    logic [31:0] w_exc_type;
    logic [31:0] w_badvaddr;
    logic        w_is_tlb;
    logic        w_is_eret;
    logic        w_load;
    logic [31:0] w_new_pc;
    logic        w_accept;

    // Forward an mtc0 that is in WB, so that a write landing this cycle is already seen.
    assign w_eff_status = (wb_cp0_we_i && wb_cp0_addr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
    assign w_eff_epc    = (wb_cp0_we_i && wb_cp0_addr_i == CP0_EPC)    ? wb_cp0_data_i : cp0_epc_i;
    assign w_eff_ebase  = (wb_cp0_we_i && wb_cp0_addr_i == CP0_EBASE)  ? wb_cp0_data_i : cp0_ebase_i;
    // Only the two software-interrupt bits of Cause are writable. The hardware IP bits always come from CP0.
    assign w_eff_ip[7:2] = cp0_cause_i[15:10];
    assign w_eff_ip[1:0] = (wb_cp0_we_i && wb_cp0_addr_i == CP0_CAUSE) ? wb_cp0_data_i[9:8]
                                                                       : cp0_cause_i[9:8];

    assign w_int_pending = (|(w_eff_ip & w_eff_status[15:8])) && w_eff_status[0] && !w_eff_status[1];

    // Bits that do not affect exception resolution, collected in one place.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, cp0_cause_i[31:16], cp0_cause_i[7:0],
                             w_eff_status[31:16], w_eff_status[7:2]};

    // Priority resolution of the exception cause, highest first.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_any      = 1'b1;
        w_exc_type = 32'h0;
        w_badvaddr = 32'h0;
        w_is_tlb   = 1'b0;
        w_is_eret  = 1'b0;
        if (w_int_pending) begin
            w_exc_type = EXC_INT;
        end else if (adel_fetch_i) begin
            w_exc_type = EXC_ADEL;
            w_badvaddr = pc_i;
        end else if (ri_i) begin
            w_exc_type = EXC_RI;
        end else if (ov_i) begin
            w_exc_type = EXC_OV;
        end else if (trap_i) begin
            w_exc_type = EXC_TRAP;
        end else if (syscall_i) begin
            w_exc_type = EXC_SYSCALL;
        end else if (break_i) begin
            w_exc_type = EXC_BREAK;
        end else if (eret_i) begin
            w_exc_type = EXC_ERET;
            w_is_eret  = 1'b1;
        end else if (adel_i) begin
            w_exc_type = EXC_ADEL;
            w_badvaddr = badvaddr_data_i;
        end else if (ades_i) begin
            w_exc_type = EXC_ADES;
            w_badvaddr = badvaddr_data_i;
        end else if (tlbmiss_i) begin
            w_exc_type = EXC_TLB;
            w_badvaddr = badvaddr_data_i;
            w_is_tlb   = 1'b1;
        end else begin
            w_any = 1'b0;
        end
    end

    assign w_load = w_is_tlb & load_i;

    // Select the redirect target. A TLB refill outside EXL uses the EBase vector directly.
    always_comb begin
        if (w_is_eret) begin
            w_new_pc = w_eff_epc;
        end else if (w_is_tlb && !w_eff_status[1]) begin
            w_new_pc = w_eff_ebase;
        end else begin
            w_new_pc = w_eff_ebase + VEC_OFFSET;
        end
    end

    assign w_accept = (r_state == S_IDLE) && !stall_i && valid_i && w_any;

    // Flush FSM. It owns the counter and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments. Every read in this block therefore sees pre-edge values.
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            exc_type_o      <= 32'h0;
            exc_addr_o      <= 32'h0;
            in_delay_slot_o <= 1'b0;
            tlbmiss_o       <= 1'b0;
            load_o          <= 1'b0;
            badvaddr_o      <= 32'h0;
            flush_o         <= 1'b0;
            new_pc_o        <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state         <= S_FLUSH;
                        r_cnt           <= CNT_INIT;
                        exc_type_o      <= w_exc_type;
                        exc_addr_o      <= pc_i;
                        in_delay_slot_o <= in_delay_slot_i;
                        tlbmiss_o       <= w_is_tlb;
                        load_o          <= w_load;
                        badvaddr_o      <= w_badvaddr;
                        flush_o         <= 1'b1;
                        new_pc_o        <= w_new_pc;
                    end
                end
                S_FLUSH: begin
                    // The CP0 exception outputs pulse only in the first flush cycle.
                    exc_type_o      <= 32'h0;
                    exc_addr_o      <= 32'h0;
                    in_delay_slot_o <= 1'b0;
                    tlbmiss_o       <= 1'b0;
                    load_o          <= 1'b0;
                    badvaddr_o      <= 32'h0;
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed test of exc_ctrl. The bench uses two instances: one with a
// single-cycle flush, and one with FLUSH_CYCLES=3 for the flush-length, stall and
// reset cases.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        valid1;
    logic        valid3;
    logic [31:0] pc_i;
    logic        in_delay_slot_i;
    logic        adel_fetch_i, ri_i, ov_i, trap_i, syscall_i, break_i, eret_i, adel_i, ades_i;
    logic        tlbmiss_i, load_i;
    logic [31:0] badvaddr_data_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_addr_i;
    logic [31:0] wb_cp0_data_i;

    logic [31:0] exc_type1, exc_addr1, badv1, new_pc1;
    logic        ids1, tlb1, load1, flush1;
    logic [31:0] exc_type3, exc_addr3, badv3, new_pc3;
    logic        ids3, tlb3, load3, flush3;

    int n_checks = 0;
    int n_errors = 0;

    exc_ctrl u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid1), .pc_i(pc_i),
        .in_delay_slot_i(in_delay_slot_i), .adel_fetch_i(adel_fetch_i), .ri_i(ri_i),
        .ov_i(ov_i), .trap_i(trap_i), .syscall_i(syscall_i), .break_i(break_i),
        .eret_i(eret_i), .adel_i(adel_i), .ades_i(ades_i), .tlbmiss_i(tlbmiss_i),
        .load_i(load_i), .badvaddr_data_i(badvaddr_data_i), .cp0_status_i(cp0_status_i),
        .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_addr_i(wb_cp0_addr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .exc_type_o(exc_type1), .exc_addr_o(exc_addr1), .in_delay_slot_o(ids1),
        .tlbmiss_o(tlb1), .load_o(load1), .badvaddr_o(badv1), .flush_o(flush1),
        .new_pc_o(new_pc1)
    );

    exc_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid3), .pc_i(pc_i),
        .in_delay_slot_i(in_delay_slot_i), .adel_fetch_i(adel_fetch_i), .ri_i(ri_i),
        .ov_i(ov_i), .trap_i(trap_i), .syscall_i(syscall_i), .break_i(break_i),
        .eret_i(eret_i), .adel_i(adel_i), .ades_i(ades_i), .tlbmiss_i(tlbmiss_i),
        .load_i(load_i), .badvaddr_data_i(badvaddr_data_i), .cp0_status_i(cp0_status_i),
        .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_addr_i(wb_cp0_addr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .exc_type_o(exc_type3), .exc_addr_o(exc_addr3), .in_delay_slot_o(ids3),
        .tlbmiss_o(tlb3), .load_o(load3), .badvaddr_o(badv3), .flush_o(flush3),
        .new_pc_o(new_pc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 1'b0; valid1 = 1'b0; valid3 = 1'b0; pc_i = 32'h0; in_delay_slot_i = 1'b0;
        adel_fetch_i = 1'b0; ri_i = 1'b0; ov_i = 1'b0; trap_i = 1'b0; syscall_i = 1'b0;
        break_i = 1'b0; eret_i = 1'b0; adel_i = 1'b0; ades_i = 1'b0; tlbmiss_i = 1'b0;
        load_i = 1'b0; badvaddr_data_i = 32'h0; cp0_status_i = 32'h0; cp0_cause_i = 32'h0;
        cp0_epc_i = 32'h0; cp0_ebase_i = 32'h8000_0000; wb_cp0_we_i = 1'b0;
        wb_cp0_addr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_exc_type", exc_type1, 32'h0);
        check("rst_exc_addr", exc_addr1, 32'h0);
        check("rst_flags", {28'h0, ids1, tlb1, load1, flush1}, 32'h0);
        check("rst_badv", badv1, 32'h0);
        check("rst_new_pc", new_pc1, 32'h0);
        check("rst_flush3", {31'h0, flush3}, 32'h0);
        rst = 1'b0;

        // Basic syscall
        valid1 = 1'b1; syscall_i = 1'b1; pc_i = 32'h8000_1000;
        step();
        check("sys_type", exc_type1, 32'h8);
        check("sys_addr", exc_addr1, 32'h8000_1000);
        check("sys_new_pc", new_pc1, 32'h8000_0180);
        check("sys_flush", {31'h0, flush1}, 32'h1);
        clear_inputs();
        step();
        check("sys_flush_end", {31'h0, flush1}, 32'h0);
        check("sys_type_end", exc_type1, 32'h0);

        // ov beats ades, delay slot propagated, badvaddr zero
        valid1 = 1'b1; ov_i = 1'b1; ades_i = 1'b1; in_delay_slot_i = 1'b1;
        badvaddr_data_i = 32'h1234_5678; pc_i = 32'h8000_2004;
        step();
        check("ov_type", exc_type1, 32'hc);
        check("ov_ids", {31'h0, ids1}, 32'h1);
        check("ov_badv", badv1, 32'h0);
        clear_inputs();
        step();

        // Interrupt beats syscall
        valid1 = 1'b1; syscall_i = 1'b1; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
        pc_i = 32'h8000_3000;
        step();
        check("int_type", exc_type1, 32'h1);
        check("int_addr", exc_addr1, 32'h8000_3000);
        check("int_new_pc", new_pc1, 32'h8000_0180);
        clear_inputs();
        step();
        // EXL set masks the interrupt
        valid1 = 1'b1; syscall_i = 1'b1; cp0_status_i = 32'h0000_FF03; cp0_cause_i = 32'h0000_0400;
        step();
        check("exl_type", exc_type1, 32'h8);
        clear_inputs();
        step();
        // mtc0 STATUS clearing IE in WB blocks the interrupt
        valid1 = 1'b1; syscall_i = 1'b1; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400;
        wb_cp0_we_i = 1'b1; wb_cp0_addr_i = 5'd12; wb_cp0_data_i = 32'h0000_FF00;
        step();
        check("ie_fwd_type", exc_type1, 32'h8);
        clear_inputs();
        step();
        // Software interrupt raised through a forwarded Cause write, with no other cause
        valid1 = 1'b1; cp0_status_i = 32'h0000_0101;
        wb_cp0_we_i = 1'b1; wb_cp0_addr_i = 5'd13; wb_cp0_data_i = 32'h0000_0100;
        step();
        check("swint_type", exc_type1, 32'h1);
        check("swint_flush", {31'h0, flush1}, 32'h1);
        clear_inputs();
        step();

        // eret with a forwarded EPC write
        valid1 = 1'b1; eret_i = 1'b1; cp0_epc_i = 32'h0000_1000;
        wb_cp0_we_i = 1'b1; wb_cp0_addr_i = 5'd14; wb_cp0_data_i = 32'h0000_2000;
        step();
        check("eret_type", exc_type1, 32'he);
        check("eret_new_pc", new_pc1, 32'h0000_2000);
        clear_inputs();
        step();

        // TLB refill on a load with EXL clear
        valid1 = 1'b1; tlbmiss_i = 1'b1; load_i = 1'b1; badvaddr_data_i = 32'h0040_0010;
        step();
        check("tlb_type", exc_type1, 32'h0);
        check("tlb_flags", {29'h0, tlb1, load1, flush1}, 32'h7);
        check("tlb_badv", badv1, 32'h0040_0010);
        check("tlb_new_pc", new_pc1, 32'h8000_0000);
        clear_inputs();
        step();
        check("tlb_pulse_end", {30'h0, tlb1, flush1}, 32'h0);
        // TLB miss with EXL set uses the general vector
        valid1 = 1'b1; tlbmiss_i = 1'b1; cp0_status_i = 32'h0000_0002; badvaddr_data_i = 32'h0040_0020;
        step();
        check("tlb_exl_new_pc", new_pc1, 32'h8000_0180);
        clear_inputs();
        step();

        // Fetch address error reports the PC as the bad address
        valid1 = 1'b1; adel_fetch_i = 1'b1; ri_i = 1'b1; pc_i = 32'h8000_0003;
        step();
        check("adelf_type", exc_type1, 32'h4);
        check("adelf_badv", badv1, 32'h8000_0003);
        clear_inputs();
        step();

        // Bubble and cause-less instruction are never accepted
        syscall_i = 1'b1;
        step();
        check("bubble_flush", {31'h0, flush1}, 32'h0);
        clear_inputs();
        valid1 = 1'b1;
        step();
        check("nocause_flush", {31'h0, flush1}, 32'h0);

        // Stall in IDLE defers the accept
        clear_inputs();
        valid1 = 1'b1; break_i = 1'b1; stall_i = 1'b1;
        step();
        check("stall_hold", {31'h0, flush1}, 32'h0);
        stall_i = 1'b0;
        step();
        check("stall_release", exc_type1, 32'h9);
        clear_inputs();
        step();

        // Three-cycle flush: stall toggling, a repeat syscall ignored, then reset mid-flush
        valid3 = 1'b1; syscall_i = 1'b1; pc_i = 32'h8000_4000;
        step();
        check("f3_c1_flush", {31'h0, flush3}, 32'h1);
        check("f3_c1_type", exc_type3, 32'h8);
        check("f3_c1_addr", exc_addr3, 32'h8000_4000);
        stall_i = 1'b1;
        step();
        check("f3_c2_flush", {31'h0, flush3}, 32'h1);
        check("f3_c2_type", exc_type3, 32'h0);
        stall_i = 1'b0;
        step();
        check("f3_c3_flush", {31'h0, flush3}, 32'h1);
        check("f3_c3_new_pc", new_pc3, 32'h8000_0180);
        stall_i = 1'b1;
        step();
        check("f3_done", {31'h0, flush3}, 32'h0);
        step();
        check("f3_stalled_idle", {31'h0, flush3}, 32'h0);
        stall_i = 1'b0;
        step();
        check("f3_reaccept", {31'h0, flush3}, 32'h1);
        check("f3_reaccept_type", exc_type3, 32'h8);
        valid3 = 1'b0; syscall_i = 1'b0;
        step();
        check("f3_r_c2_flush", {31'h0, flush3}, 32'h1);
        rst = 1'b1;
        step();
        check("f3_rst_flush", {31'h0, flush3}, 32'h0);
        check("f3_rst_new_pc", new_pc3, 32'h0);
        check("f3_rst_type", exc_type3, 32'h0);
        rst = 1'b0;
        step();
        check("f3_post_rst", {31'h0, flush3}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
